// File: rtl/spi_regbank.sv
// spi_regbank: SPI mode-0 slave register bank.
//   Exposes N_RW writable words (addresses 0..N_RW-1) and N_RD read-only
//   words (addresses N_RW..N_RW+N_RD-1) to an external SPI master. A frame
//   is one command word (MSB = write flag, rest = start address) followed
//   by one or more data words. The address auto-increments between words.
//   Aborted frames are counted.
// Ports:
//   theClock, theReset  - system clock, async active-high reset
//   spi_clk/cs/sdi      - raw SPI pins from the master (asynchronous)
//   spi_sdo             - read data to the master, MSB first
//   rd_data             - read-only words, word k at [k*DATA_W +: DATA_W]
//   rw_regs             - writable register contents, same packing
//   wr_strobe           - one-cycle pulse on the register being written
//   busy                - frame in progress
//   err_cnt             - saturating count of aborted frames
module spi_regbank #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 16,
    parameter int                N_RW      = 4,
    parameter int                N_RD      = 16,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                     theClock,
    input  logic                     theReset,
    input  logic                     spi_clk,
    input  logic                     spi_cs,
    input  logic                     spi_sdi,
    output logic                     spi_sdo,
    input  logic [N_RD*DATA_W-1:0]   rd_data,
    output logic [N_RW*DATA_W-1:0]   rw_regs,
    output logic [N_RW-1:0]          wr_strobe,
    output logic                     busy,
    output logic [7:0]               err_cnt
);

    localparam int AW   = ADDR_W - 1;
    localparam int MAXW = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam int CW   = $clog2(MAXW + 1);

    typedef enum logic [2:0] {IDLE, ADDR, LOAD, DATA, COMMIT} state_t;

    state_t                         state_q, state_d;
    logic [2:0]                     clk_sr;
    logic [1:0]                     cs_sr, sdi_sr;
    logic                           sclk_rise, sclk_fall, cs_hi, sdi_s;
    logic                           armed_q;
    logic [CW-1:0]                  cnt_q;
    logic [ADDR_W-1:0]              cmd_q;
    logic [AW-1:0]                  addr_q, ld_addr;
    logic                           wr_flag_q, burst_q;
    logic [DATA_W-1:0]              shift_in_q, shift_out_q, ld_word;
    logic [7:0]                     err_q;
    logic [N_RW-1:0][DATA_W-1:0]    rw_q;
    logic [N_RD-1:0][DATA_W-1:0]    rd_arr;

    assign rd_arr  = rd_data;
    assign rw_regs = rw_q;
    assign err_cnt = err_q;

    // Two-flop synchronisers; clk_sr[2] is the previous synced value for
    // edge detection. cs resets to "selected" so a frame that was in flight
    // when reset hit cannot restart until cs is seen high (see armed_q).
    always_ff @(posedge theClock or posedge theReset) begin
        if (theReset) begin
            clk_sr <= '0;
            cs_sr  <= '0;
            sdi_sr <= '0;
        end else begin
            clk_sr <= {clk_sr[1:0], spi_clk};
            cs_sr  <= {cs_sr[0], spi_cs};
            sdi_sr <= {sdi_sr[0], spi_sdi};
        end
    end

    assign sclk_rise = clk_sr[1] & ~clk_sr[2];
    assign sclk_fall = ~clk_sr[1] & clk_sr[2];
    assign cs_hi     = cs_sr[1];
    assign sdi_s     = sdi_sr[1];

    // First word of a frame takes its address from the command; later burst
    // words use the incremented address.
    assign ld_addr = burst_q ? addr_q : cmd_q[ADDR_W-2:0];

    always_comb begin
        ld_word = '0;
        for (int k = 0; k < N_RW; k++)
            if (int'(ld_addr) == k) ld_word = rw_q[k];
        for (int k = 0; k < N_RD; k++)
            if (int'(ld_addr) == N_RW + k) ld_word = rd_arr[k];
    end

    // State register
    always_ff @(posedge theClock or posedge theReset) begin
        if (theReset) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (armed_q && !cs_hi) state_d = ADDR;
            ADDR:    if (sclk_rise && cnt_q == CW'(ADDR_W - 1)) state_d = LOAD;
            LOAD:    state_d = DATA;
            DATA:    if (sclk_rise && cnt_q == CW'(DATA_W - 1)) state_d = COMMIT;
            COMMIT:  state_d = LOAD;
            default: state_d = IDLE;
        endcase
        // cs deassertion wins over everything
        if (state_q != IDLE && cs_hi) state_d = IDLE;
    end

    // Outputs
    always_comb begin
        busy      = (state_q != IDLE);
        spi_sdo   = (state_q == LOAD || state_q == DATA) ? shift_out_q[DATA_W-1] : 1'b0;
        wr_strobe = '0;
        for (int k = 0; k < N_RW; k++)
            if (state_q == COMMIT && wr_flag_q && int'(addr_q) == k) wr_strobe[k] = 1'b1;
    end

    // Datapath
    always_ff @(posedge theClock or posedge theReset) begin
        if (theReset) begin
            armed_q     <= 1'b0;
            cnt_q       <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            wr_flag_q   <= 1'b0;
            burst_q     <= 1'b0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            err_q       <= '0;
        end else begin
            if (cs_hi) armed_q <= 1'b1;
            // A frame dropped with a partially shifted word is an error.
            if (cs_hi && (state_q == ADDR || state_q == DATA) &&
                cnt_q != '0 && err_q != 8'hFF)
                err_q <= err_q + 8'd1;
            case (state_q)
                IDLE: begin
                    cnt_q       <= '0;
                    cmd_q       <= '0;
                    burst_q     <= 1'b0;
                    shift_in_q  <= '0;
                    shift_out_q <= '0;
                end
                ADDR: if (sclk_rise) begin
                    cmd_q <= {cmd_q[ADDR_W-2:0], sdi_s};
                    cnt_q <= cnt_q + CW'(1);
                end
                LOAD: begin
                    if (!burst_q) begin
                        addr_q    <= cmd_q[ADDR_W-2:0];
                        wr_flag_q <= cmd_q[ADDR_W-1];
                    end
                    shift_out_q <= ld_word;   // coherent snapshot of the word
                    cnt_q       <= '0;
                end
                DATA: begin
                    if (sclk_rise) begin
                        shift_in_q <= {shift_in_q[DATA_W-2:0], sdi_s};
                        cnt_q      <= cnt_q + CW'(1);
                    end
                    // The MSB is presented before the first data rise, so the
                    // fall preceding it (cnt 0) must not shift it away.
                    if (sclk_fall && cnt_q != '0)
                        shift_out_q <= {shift_out_q[DATA_W-2:0], 1'b0};
                end
                COMMIT: begin
                    addr_q  <= addr_q + AW'(1);
                    burst_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Writable registers; the word commits even if cs rises during COMMIT.
    always_ff @(posedge theClock or posedge theReset) begin
        if (theReset) begin
            for (int k = 0; k < N_RW; k++) rw_q[k] <= RESET_VAL;
        end else begin
            for (int k = 0; k < N_RW; k++)
                if (wr_strobe[k]) rw_q[k] <= shift_in_q;
        end
    end

endmodule
